// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: sync, debounce and press-edge logic for two
// push buttons feeding the A/B sequence detector; chords are locked out.
module key_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_pulse,
  output logic b_pulse,
  output logic a_level,
  output logic b_level
);

  typedef enum logic [1:0] {
    RELEASED = 2'b00,
    PULSE    = 2'b01,
    HELD     = 2'b10
  } press_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] lvl;
  logic [1:0] pulse;

  assign raw = {b_raw, a_raw};

  // two-flop synchronizer for both raw inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             lvl_q;
    logic             pulse_q;
    press_t           state;

    assign lvl[i]   = lvl_q;
    assign pulse[i] = pulse_q;

    // accept a new level only after it has been stable long enough
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        lvl_q <= 1'b0;
      end else if (s2[i] == lvl_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl_q <= s2[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    // press FSM: one pulse per solo press, chords go straight to HELD
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= RELEASED;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state)
          RELEASED: begin
            if (lvl_q) begin
              if (lvl[1-i]) begin
                state <= HELD;
              end else begin
                state   <= PULSE;
                pulse_q <= 1'b1;
              end
            end
          end
          PULSE: state <= HELD;
          HELD: begin
            if (!lvl_q)
              state <= RELEASED;
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

  assign a_level = lvl[0];
  assign b_level = lvl[1];
  assign a_pulse = pulse[0];
  assign b_pulse = pulse[1];

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// tb_key_pulse_conditioner: directed checks of latency, bounce rejection,
// chord lockout, overlap, long hold and reset behaviour.
module tb_key_pulse_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic a_raw;
  logic b_raw;
  logic a_pulse;
  logic b_pulse;
  logic a_level;
  logic b_level;

  int n_chk = 0;
  int n_err = 0;
  int pa = 0;
  int pb = 0;
  int la = 0;
  int both = 0;

  key_pulse_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_raw(a_raw),
    .b_raw(b_raw),
    .a_pulse(a_pulse),
    .b_pulse(b_pulse),
    .a_level(a_level),
    .b_level(b_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_pulse) pa++;
    if (b_pulse) pb++;
    if (a_level) la++;
    if (a_pulse && b_pulse) both++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
    step(3);
    chk("rst_a_level", a_level, 0);
    chk("rst_b_level", b_level, 0);
    chk("rst_a_pulse", a_pulse, 0);
    chk("rst_b_pulse", b_pulse, 0);
    reset = 1'b0;
    step(4);

    // 1: clean press
    pa = 0; pb = 0;
    a_raw = 1'b1;
    step(5);
    chk("t1_lvl_k4", a_level, 0);
    step(1);
    chk("t1_lvl_k5", a_level, 1);
    chk("t1_pls_k5", a_pulse, 0);
    step(1);
    chk("t1_pls_k6", a_pulse, 1);
    step(1);
    chk("t1_pls_k7", a_pulse, 0);
    step(10);
    chk("t1_pa", pa, 1);
    chk("t1_pb", pb, 0);
    chk("t1_blvl", b_level, 0);
    a_raw = 1'b0;
    step(10);
    chk("t1_rel", a_level, 0);

    // 2: bounce
    pa = 0; la = 0;
    for (int i = 0; i < 10; i++) begin
      a_raw = ~a_raw;
      step(2);
    end
    a_raw = 1'b0;
    step(10);
    chk("t2_pa", pa, 0);
    chk("t2_la", la, 0);

    // 3: chord
    pa = 0; pb = 0;
    a_raw = 1'b1;
    b_raw = 1'b1;
    step(5);
    chk("t3_a_k4", a_level, 0);
    chk("t3_b_k4", b_level, 0);
    step(1);
    chk("t3_a_k5", a_level, 1);
    chk("t3_b_k5", b_level, 1);
    step(10);
    chk("t3_pa", pa, 0);
    chk("t3_pb", pb, 0);
    a_raw = 1'b0;
    b_raw = 1'b0;
    step(10);
    chk("t3_a_rel", a_level, 0);
    chk("t3_b_rel", b_level, 0);
    b_raw = 1'b1;
    step(10);
    chk("t3_solo_pb", pb, 1);
    chk("t3_solo_pa", pa, 0);
    b_raw = 1'b0;
    step(10);

    // 4: overlap
    pa = 0; pb = 0;
    a_raw = 1'b1;
    step(10);
    chk("t4_pa", pa, 1);
    b_raw = 1'b1;
    step(10);
    chk("t4_blvl", b_level, 1);
    chk("t4_pb", pb, 0);
    a_raw = 1'b0;
    step(10);
    chk("t4_alvl", a_level, 0);
    chk("t4_pa_rel", pa, 1);
    chk("t4_pb_rel", pb, 0);
    b_raw = 1'b0;
    step(10);
    chk("t4_pb_end", pb, 0);

    // 5: long hold
    pa = 0;
    a_raw = 1'b1;
    step(100);
    chk("t5_pa_hold", pa, 1);
    a_raw = 1'b0;
    step(5);
    chk("t5_rel_k4", a_level, 1);
    step(1);
    chk("t5_rel_k5", a_level, 0);
    step(10);
    chk("t5_pa_rel", pa, 1);
    a_raw = 1'b1;
    step(10);
    chk("t5_pa_again", pa, 2);
    a_raw = 1'b0;
    step(10);

    // 6: reset mid-count and mid-pulse
    a_raw = 1'b1;
    step(4);
    reset = 1'b1;
    step(1);
    chk("t6_cnt_lvl", a_level, 0);
    chk("t6_cnt_pls", a_pulse, 0);
    reset = 1'b0;
    step(5);
    chk("t6_lvl_j4", a_level, 0);
    step(1);
    chk("t6_lvl_j5", a_level, 1);
    step(1);
    chk("t6_pls_j6", a_pulse, 1);
    reset = 1'b1;
    step(1);
    chk("t6_pr_pls", a_pulse, 0);
    chk("t6_pr_lvl", a_level, 0);
    chk("t6_pr_blvl", b_level, 0);
    pa = 0;
    reset = 1'b0;
    step(5);
    chk("t6_re_j4", a_level, 0);
    step(1);
    chk("t6_re_j5", a_level, 1);
    step(1);
    chk("t6_re_pls", a_pulse, 1);
    step(10);
    chk("t6_re_pa", pa, 1);

    chk("never_both", both, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
